// File: rtl/dp_ram_clear.sv
// True dual-port synchronous RAM with a clear-on-reset sequencer, per-port
// read-valid strobes, selectable read-during-write and optional output stage.
module dp_ram_clear #(
   parameter int DATA           = 16,
   parameter int ADDR           = 13,
   parameter int RDW_MODE       = 0,
   parameter int OUT_REG        = 0,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            a_en,
   input  logic            a_wr,
   input  logic [ADDR-1:0] a_addr,
   input  logic [DATA-1:0] a_din,
   output logic [DATA-1:0] a_dout,
   output logic            a_valid,
   input  logic            b_en,
   input  logic            b_wr,
   input  logic [ADDR-1:0] b_addr,
   input  logic [DATA-1:0] b_din,
   output logic [DATA-1:0] b_dout,
   output logic            b_valid,
   output logic            busy,
   output logic            collision
);

   localparam int DEPTH = 2 ** ADDR;
   localparam logic [ADDR:0] LAST_PTR = (ADDR + 1)'(DEPTH - 1);

   typedef enum logic {IDLE, CLEAR} state_t;

   state_t          state, state_nxt;
   logic [ADDR:0]   ptr, ptr_nxt;
   logic            clr_we;

   logic [DATA-1:0] mem [DEPTH];

   logic            a_acc, b_acc, a_we, b_we, same_addr, conflict;
   logic [DATA-1:0] a_rdata, b_rdata;

   logic [DATA-1:0] a_dout_p0, b_dout_p0;
   logic            a_vld_p0, b_vld_p0, collision_p0;

   // Clear sequencer state register
   always_ff @(posedge clk) begin
      if (reset) begin
         if (CLEAR_ON_RESET != 0) state <= CLEAR;
         else                     state <= IDLE;
         ptr <= '0;
      end else begin
         state <= state_nxt;
         ptr   <= ptr_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      ptr_nxt   = ptr;
      clr_we    = 1'b0;
      busy      = 1'b0;
      case (state)
         CLEAR: begin
            busy    = 1'b1;
            clr_we  = 1'b1;
            ptr_nxt = ptr + 1'b1;
            if (ptr == LAST_PTR) state_nxt = IDLE;
         end
         default: ;
      endcase
   end

   // Port A wins a same-address double write; B's write is discarded.
   always_comb begin
      a_acc     = a_en && !busy && !reset;
      b_acc     = b_en && !busy && !reset;
      same_addr = (a_addr == b_addr);
      a_we      = a_acc && a_wr;
      b_we      = b_acc && b_wr && !(a_we && same_addr);
      conflict  = a_acc && b_acc && same_addr && (a_wr || b_wr);
   end

   // Write-first returns whatever word lands at the address this edge.
   always_comb begin
      a_rdata = mem[a_addr];
      b_rdata = mem[b_addr];
      if (RDW_MODE == 0) begin
         if (a_we)                  a_rdata = a_din;
         else if (b_we && same_addr) a_rdata = b_din;
         if (b_we)                  b_rdata = b_din;
         else if (a_we && same_addr) b_rdata = a_din;
      end
   end

   always_ff @(posedge clk) begin
      if (clr_we && !reset) mem[ptr[ADDR-1:0]] <= '0;
      if (a_we)             mem[a_addr]        <= a_din;
      if (b_we)             mem[b_addr]        <= b_din;
   end

   // Stage p0: array read result, valid strobes and collision flag
   always_ff @(posedge clk) begin
      if (reset) begin
         a_dout_p0    <= '0;
         b_dout_p0    <= '0;
         a_vld_p0     <= 1'b0;
         b_vld_p0     <= 1'b0;
         collision_p0 <= 1'b0;
      end else begin
         a_vld_p0     <= a_acc;
         b_vld_p0     <= b_acc;
         collision_p0 <= conflict;
         if (a_acc) a_dout_p0 <= a_rdata;
         if (b_acc) b_dout_p0 <= b_rdata;
      end
   end

   assign collision = collision_p0;

   // Stage p1: optional output register; data holds between valid results
   if (OUT_REG != 0) begin : g_out_reg
      logic [DATA-1:0] a_dout_p1, b_dout_p1;
      logic            a_vld_p1, b_vld_p1;

      always_ff @(posedge clk) begin
         if (reset) begin
            a_dout_p1 <= '0;
            b_dout_p1 <= '0;
            a_vld_p1  <= 1'b0;
            b_vld_p1  <= 1'b0;
         end else begin
            a_vld_p1 <= a_vld_p0;
            b_vld_p1 <= b_vld_p0;
            if (a_vld_p0) a_dout_p1 <= a_dout_p0;
            if (b_vld_p0) b_dout_p1 <= b_dout_p0;
         end
      end

      assign a_dout  = a_dout_p1;
      assign b_dout  = b_dout_p1;
      assign a_valid = a_vld_p1;
      assign b_valid = b_vld_p1;
   end else begin : g_no_out_reg
      assign a_dout  = a_dout_p0;
      assign b_dout  = b_dout_p0;
      assign a_valid = a_vld_p0;
      assign b_valid = b_vld_p0;
   end

endmodule

// File: tb/tb_dp_ram_clear.sv
// Directed bench for dp_ram_clear: write-first/no-output-reg, read-first/output-reg
// and no-clear instances share one stimulus stream.
module tb_dp_ram_clear;

   localparam int DW = 16;
   localparam int AW = 4;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          a_en = 1'b0, a_wr = 1'b0, b_en = 1'b0, b_wr = 1'b0;
   logic [AW-1:0] a_addr = '0, b_addr = '0;
   logic [DW-1:0] a_din = '0, b_din = '0;

   logic [DW-1:0] u0_a_dout, u0_b_dout, u1_a_dout, u1_b_dout, u2_a_dout, u2_b_dout;
   logic          u0_a_valid, u0_b_valid, u0_busy, u0_col;
   logic          u1_a_valid, u1_b_valid, u1_busy, u1_col;
   logic          u2_a_valid, u2_b_valid, u2_busy, u2_col;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   dp_ram_clear #(.DATA(DW), .ADDR(AW), .RDW_MODE(0), .OUT_REG(0), .CLEAR_ON_RESET(1)) u0 (
      .clk(clk), .reset(reset),
      .a_en(a_en), .a_wr(a_wr), .a_addr(a_addr), .a_din(a_din), .a_dout(u0_a_dout), .a_valid(u0_a_valid),
      .b_en(b_en), .b_wr(b_wr), .b_addr(b_addr), .b_din(b_din), .b_dout(u0_b_dout), .b_valid(u0_b_valid),
      .busy(u0_busy), .collision(u0_col));

   dp_ram_clear #(.DATA(DW), .ADDR(AW), .RDW_MODE(1), .OUT_REG(1), .CLEAR_ON_RESET(1)) u1 (
      .clk(clk), .reset(reset),
      .a_en(a_en), .a_wr(a_wr), .a_addr(a_addr), .a_din(a_din), .a_dout(u1_a_dout), .a_valid(u1_a_valid),
      .b_en(b_en), .b_wr(b_wr), .b_addr(b_addr), .b_din(b_din), .b_dout(u1_b_dout), .b_valid(u1_b_valid),
      .busy(u1_busy), .collision(u1_col));

   dp_ram_clear #(.DATA(DW), .ADDR(AW), .RDW_MODE(0), .OUT_REG(0), .CLEAR_ON_RESET(0)) u2 (
      .clk(clk), .reset(reset),
      .a_en(a_en), .a_wr(a_wr), .a_addr(a_addr), .a_din(a_din), .a_dout(u2_a_dout), .a_valid(u2_a_valid),
      .b_en(b_en), .b_wr(b_wr), .b_addr(b_addr), .b_din(b_din), .b_dout(u2_b_dout), .b_valid(u2_b_valid),
      .busy(u2_busy), .collision(u2_col));

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      a_en = 1'b0; a_wr = 1'b0;
      b_en = 1'b0; b_wr = 1'b0;
   endtask

   task automatic drive(input logic ae, input logic aw, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                        input logic be, input logic bw, input logic [AW-1:0] ba, input logic [DW-1:0] bd);
      a_en = ae; a_wr = aw; a_addr = aa; a_din = ad;
      b_en = be; b_wr = bw; b_addr = ba; b_din = bd;
   endtask

   // One transaction; u0 checked one edge later, u1 two edges later.
   task automatic xact(input string tag,
                       input logic ae, input logic aw, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                       input logic be, input logic bw, input logic [AW-1:0] ba, input logic [DW-1:0] bd,
                       input logic [DW-1:0] a0, input logic [DW-1:0] b0,
                       input logic [DW-1:0] a1, input logic [DW-1:0] b1, input logic col);
      drive(ae, aw, aa, ad, be, bw, ba, bd);
      step();
      idle();
      chk({tag, ".u0_av"}, u0_a_valid, ae);
      chk({tag, ".u0_bv"}, u0_b_valid, be);
      if (ae) chk({tag, ".u0_a"}, u0_a_dout, a0);
      if (be) chk({tag, ".u0_b"}, u0_b_dout, b0);
      chk({tag, ".u0_col"}, u0_col, col);
      chk({tag, ".u1_col"}, u1_col, col);
      chk({tag, ".u1_av_early"}, u1_a_valid, 1'b0);
      chk({tag, ".u1_bv_early"}, u1_b_valid, 1'b0);
      step();
      chk({tag, ".u1_av"}, u1_a_valid, ae);
      chk({tag, ".u1_bv"}, u1_b_valid, be);
      if (ae) chk({tag, ".u1_a"}, u1_a_dout, a1);
      if (be) chk({tag, ".u1_b"}, u1_b_dout, b1);
      chk({tag, ".u0_av_off"}, u0_a_valid, 1'b0);
      if (ae) chk({tag, ".u0_a_hold"}, u0_a_dout, a0);
      chk({tag, ".u0_col_off"}, u0_col, 1'b0);
      chk({tag, ".u1_col_off"}, u1_col, 1'b0);
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, ".u0_a"}, u0_a_dout, 0);
      chk({tag, ".u0_b"}, u0_b_dout, 0);
      chk({tag, ".u0_av"}, u0_a_valid, 0);
      chk({tag, ".u0_bv"}, u0_b_valid, 0);
      chk({tag, ".u0_col"}, u0_col, 0);
      chk({tag, ".u0_busy"}, u0_busy, 1);
      chk({tag, ".u1_a"}, u1_a_dout, 0);
      chk({tag, ".u1_b"}, u1_b_dout, 0);
      chk({tag, ".u1_av"}, u1_a_valid, 0);
      chk({tag, ".u1_bv"}, u1_b_valid, 0);
      chk({tag, ".u1_busy"}, u1_busy, 1);
      chk({tag, ".u2_busy"}, u2_busy, 0);
      chk({tag, ".u2_a"}, u2_a_dout, 0);
   endtask

   // Counts busy samples starting at the cycle reset drops; bounded at 40.
   task automatic count_busy(input string tag);
      int c0 = 0, c1 = 0, vcnt = 0;
      for (int k = 0; k < 40; k++) begin
         if (!(u0_busy || u1_busy)) break;
         if (u0_busy) c0++;
         if (u1_busy) c1++;
         if (u0_a_valid || u0_b_valid || u1_a_valid || u1_b_valid) vcnt++;
         step();
      end
      idle();
      chk({tag, ".u0_busy_cycles"}, c0, 16);
      chk({tag, ".u1_busy_cycles"}, c1, 16);
      chk({tag, ".valid_while_busy"}, vcnt, 0);
      chk({tag, ".u2_busy"}, u2_busy, 0);
   endtask

   initial begin
      idle();
      reset = 1'b1;
      step();
      step();
      check_reset_values("rst");

      // Requests held on throughout the clear must all be dropped.
      reset = 1'b0;
      drive(1'b1, 1'b0, 4'd2, 16'h0000, 1'b1, 1'b1, 4'd2, 16'hBEEF);
      count_busy("clear0");

      //   tag       ae aw aa  ad        be bw ba  bd        u0 a     u0 b     u1 a     u1 b     col
      xact("rd2",    1, 0, 2,  16'h0,    0, 0, 0,  16'h0,    16'h0,   16'h0,   16'h0,   16'h0,   0);
      xact("wr3",    1, 1, 3,  16'h1234, 0, 0, 0,  16'h0,    16'h1234,16'h0,   16'h0,   16'h0,   0);
      xact("rd3b",   0, 0, 0,  16'h0,    1, 0, 3,  16'h0,    16'h0,   16'h1234,16'h0,   16'h1234,0);
      xact("pre5",   1, 1, 5,  16'h00AA, 0, 0, 0,  16'h0,    16'h00AA,16'h0,   16'h0,   16'h0,   0);
      xact("rdw5",   1, 1, 5,  16'h0055, 0, 0, 0,  16'h0,    16'h0055,16'h0,   16'h00AA,16'h0,   0);
      xact("rd5",    1, 0, 5,  16'h0,    0, 0, 0,  16'h0,    16'h0055,16'h0,   16'h0055,16'h0,   0);
      xact("ww7",    1, 1, 7,  16'h1111, 1, 1, 7,  16'h2222, 16'h1111,16'h1111,16'h0,   16'h0,   1);
      xact("rd7",    0, 0, 0,  16'h0,    1, 0, 7,  16'h0,    16'h0,   16'h1111,16'h0,   16'h1111,0);
      xact("pre9",   0, 0, 0,  16'h0,    1, 1, 9,  16'h0F0F, 16'h0,   16'h0F0F,16'h0,   16'h0,   0);
      xact("wr9",    1, 1, 9,  16'hF0F0, 1, 0, 9,  16'h0,    16'hF0F0,16'hF0F0,16'h0F0F,16'h0F0F,1);
      xact("rr9",    1, 0, 9,  16'h0,    1, 0, 9,  16'h0,    16'hF0F0,16'hF0F0,16'hF0F0,16'hF0F0,0);
      xact("rd35",   1, 0, 3,  16'h0,    1, 0, 5,  16'h0,    16'h1234,16'h0055,16'h1234,16'h0055,0);
      xact("wr46",   1, 1, 4,  16'h4444, 1, 1, 6,  16'h6666, 16'h4444,16'h6666,16'h0,   16'h0,   0);
      xact("rd46",   1, 0, 4,  16'h0,    1, 0, 6,  16'h0,    16'h4444,16'h6666,16'h4444,16'h6666,0);

      // Back-to-back reads on port A through the output register.
      drive(1'b1, 1'b0, 4'd3, 16'h0, 1'b0, 1'b0, 4'd0, 16'h0);
      step();
      drive(1'b1, 1'b0, 4'd5, 16'h0, 1'b0, 1'b0, 4'd0, 16'h0);
      step();
      idle();
      chk("burst.u0_a2", u0_a_dout, 16'h0055);
      chk("burst.u1_a1", u1_a_dout, 16'h1234);
      chk("burst.u1_av1", u1_a_valid, 1);
      step();
      chk("burst.u1_a2", u1_a_dout, 16'h0055);
      chk("burst.u1_av2", u1_a_valid, 1);
      step();

      // Reset lands while a u1 result is still in its output stage.
      drive(1'b1, 1'b0, 4'd3, 16'h0, 1'b0, 1'b0, 4'd0, 16'h0);
      step();
      idle();
      chk("inflight.u0_a", u0_a_dout, 16'h1234);
      reset = 1'b1;
      step();
      chk("inflight.u1_av", u1_a_valid, 0);
      chk("inflight.u1_a", u1_a_dout, 0);
      reset = 1'b0;
      for (int k = 0; k < 6; k++) step();
      chk("midclear.u0_busy", u0_busy, 1);
      reset = 1'b1;
      step();
      check_reset_values("midrst");
      reset = 1'b0;
      count_busy("clear1");

      for (int i = 0; i < 16; i++)
         xact($sformatf("zero%0d", i), 1, 0, 4'(i), 16'h0, 1, 0, 4'(15 - i), 16'h0,
              16'h0, 16'h0, 16'h0, 16'h0, 0);

      // The non-clearing instance keeps its contents across reset.
      drive(1'b1, 1'b0, 4'd3, 16'h0, 1'b0, 1'b0, 4'd0, 16'h0);
      step();
      idle();
      chk("keep.u2_a", u2_a_dout, 16'h1234);
      chk("keep.u0_a", u0_a_dout, 16'h0);
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/dp_ram_clear.md
# dp_ram_clear

Parametrised true dual-port synchronous RAM: next generation of the shared-memory primitive between the Hack CPU and video/IO side. Both ports share one clock. New over the previous generation: hardware clear-on-reset sequencer with `busy` flag, per-port access enable with read-valid strobe, selectable read-during-write mode, optional output register stage, and defined cross-port collision arbitration with a `collision` flag.

## Interface

Parameters:
- `DATA`, 16, word width in bits (1..64).
- `ADDR`, 13, address width; depth DEPTH = 2**ADDR words.
- `RDW_MODE`, 0, read-during-write to the same address: 0 = write-first (new data), 1 = read-first (old data).
- `OUT_REG`, 0, 1 adds an output pipeline register per port (read latency 2 instead of 1).
- `CLEAR_ON_RESET`, 1, 1 = zero the whole array after reset; 0 = contents untouched by reset.

Ports:
- `clk`  in  1  single clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high.
- `a_en`  in  1  port A access request this cycle.
- `a_wr`  in  1  port A write (qualified by `a_en`).
- `a_addr`  in  ADDR  port A word address.
- `a_din`  in  DATA  port A write data.
- `a_dout`  out  DATA  port A read data.
- `a_valid`  out  1  `a_dout` carries the result of an accepted port A access.
- `b_en`, `b_wr`, `b_addr`, `b_din`, `b_dout`, `b_valid`: same as port A, for port B.
- `busy`  out  1  clear sequence running; all port requests ignored.
- `collision`  out  1  one-cycle flag: cross-port conflict on the previous accepted access.

## Operation

- Accepted access: `x_en`=1 and `busy`=0. Requests while `busy`=1 are dropped: no write, no `x_valid`.
- Every accepted access (read or write) produces a `x_valid` pulse with `x_dout` updated; otherwise `x_valid`=0 and `x_dout` holds its last value.
- Write: `mem[x_addr] <= x_din`. `x_dout` on a write = `x_din` if RDW_MODE=0, previous `mem[x_addr]` if RDW_MODE=1.
- Clear FSM, states IDLE and CLEAR:
  - reset asserted: state forced to CLEAR (if CLEAR_ON_RESET=1) else IDLE; clear pointer = 0.
  - CLEAR: writes 0 to `mem[ptr]`, ptr+1 each cycle; after writing DEPTH-1 -> IDLE. Pointer is ADDR+1 bits, no wrap.
  - `busy` = (state == CLEAR).
- Cross-port conflict: both ports accepted, `a_addr`==`b_addr`, at least one write.
  - Both write: port A wins; B's write discarded; both `x_dout` report A's data (RDW_MODE=0) or the old word (RDW_MODE=1).
  - One writes, other reads: reader gets written data if RDW_MODE=0, old word if RDW_MODE=1.
  - `collision`=1 for exactly one cycle.
- Both ports reading the same address: no conflict, `collision` stays 0.

## Timing

- Reset values, all outputs: `a_dout`=`b_dout`=0, `a_valid`=`b_valid`=0, `collision`=0; `busy`=1 during reset and after it if CLEAR_ON_RESET=1, else 0.
- Clear: first cycle with `reset`=0 writes address 0; `busy` stays 1 for exactly DEPTH cycles after reset deasserts; first acceptable access on the cycle `busy` reads 0.
- Reset mid-clear: sequence restarts at address 0 with full DEPTH-cycle duration.
- Read latency: request at edge N -> `x_dout`/`x_valid` at edge N+1 (OUT_REG=0) or N+2 (OUT_REG=1). Fully pipelined: one accepted access per port per cycle.
- `collision` asserted at edge N+1 for a conflict at edge N, independent of OUT_REG.
- Write takes effect at edge N; a read of that address at edge N+1 on either port returns the new data.
- Reset during OUT_REG pipeline: in-flight results discarded, outputs return to reset values.

## Test plan

- Clear: DATA=16, ADDR=4, preload via writes, pulse reset 1 cycle -> `busy` high 16 cycles; requests during busy give no `x_valid`; then reads of all 16 addresses return 0.
- Basic R/W: A writes 0x1234 @3, next cycle B reads @3 -> `b_dout`=0x1234, `b_valid`=1 one cycle later (two with OUT_REG=1).
- Same-port RDW: @5=0x00AA, A writes 0x0055 @5 -> `a_dout`=0x0055 (RDW_MODE=0) / 0x00AA (RDW_MODE=1).
- Write/write collision: A writes 0x1111, B writes 0x2222, same addr 7 -> `collision`=1 one cycle, later read @7 = 0x1111.
- Write/read collision: @9=0x0F0F, A writes 0xF0F0 @9 while B reads @9 -> `b_dout`=0xF0F0 (mode 0) / 0x0F0F (mode 1), `collision`=1.
- Reset mid-clear at cycle 6 of 16 -> `busy` stays high 16 more cycles; outputs at reset values.
